// File: rtl/vga_copper_pkg.sv
// vga_copper_pkg: register map, program entry layout, end-of-list marker and
// sequencer state encodings shared by the copper top and its program RAM.
package vga_copper_pkg;

    // CPU-visible copper register offsets (cpu_sel = 1)
    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_PTR   = 3'd1;
    localparam logic [2:0] REG_DATA  = 3'd2;
    localparam logic [2:0] REG_STAT  = 3'd3;
    localparam logic [2:0] REG_STAT2 = 3'd4;

    // Raster line value that terminates the program list
    localparam logic [9:0] END_LINE = 10'h3FF;

    // Sequencer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One 24-bit program entry: byte2 = data, byte1 = {irq, reg, pad, line[9:8]},
    // byte0 = line[7:0]
    typedef struct packed {
        logic [7:0] data;
        logic       irq;
        logic [2:0] reg_sel;
        logic [1:0] pad;
        logic [9:0] line;
    } entry_t;

endpackage

// File: rtl/vga_copper_ram.sv
// vga_copper_ram: DEPTH x 24-bit program store. Byte-lane write port from the
// CPU pointer, registered read port for the sequencer. Contents are not reset.
module vga_copper_ram
    import vga_copper_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          cpu_clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_idx,
    input  logic [1:0]    wr_lane,
    input  logic [7:0]    wr_byte,
    input  logic [PW-1:0] rd_idx,
    output entry_t        rd_data
);

    logic [23:0] mem [DEPTH];

    // Byte write into the addressed entry; read port registered every cycle.
    // NOTE: the array carries no reset on purpose, so it maps onto block RAM.
    always_ff @(posedge cpu_clk) begin
        if (wr_en && wr_lane != 2'd3) begin
            mem[wr_idx][{wr_lane, 3'b000} +: 8] <= wr_byte;
        end
        rd_data <= entry_t'(mem[rd_idx]);
    end

endmodule

// File: rtl/vga_copper.sv
// vga_copper: raster-synchronised register sequencer ("copper").
// Replays a CPU-loaded list of {line, reg, data} entries into the video
// adapter register port once per frame; direct CPU writes always win the port.
// Build option: define VGA_COPPER_IRQ_EN to enable the raster interrupt.
module vga_copper
    import vga_copper_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int LINE_W = 10
) (
    input  logic       cpu_clk,
    input  logic       rst,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_dbw,
    input  logic       cpu_we,
    input  logic       cpu_sel,
    input  logic       hsync,
    input  logic       vsync,
    output logic [7:0] cpu_dbr,
    output logic [2:0] vga_addr,
    output logic [7:0] vga_dbw,
    output logic       vga_we,
    output logic       irq
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] PTR_ONE = {{(PW+1){1'b0}}, 1'b1};
    localparam logic [PW+1:0] PTR_TWO = {{PW{1'b0}}, 2'b10};
    localparam logic [PW:0]   IDX_ONE = {{PW{1'b0}}, 1'b1};

    logic              en;
    logic              irq_en;
    logic [PW+1:0]     ptr;       // byte pointer: {entry, lane}
    logic              hs_r, vs_r;
    logic              hs_fall, vs_fall;
    logic [LINE_W-1:0] line_cnt;
    logic [9:0]        line10;
    logic [PW:0]       idx;       // extra MSB flags a walk past the last entry
    logic [2:0]        state;
    logic              pend;
    logic              grant;
    logic              cop_wr, cpu_vga;
    logic [7:0]        rd_mux;
    entry_t            ent;
    logic              unused_bits;

    assign cop_wr  = cpu_we & cpu_sel;
    assign cpu_vga = cpu_we & ~cpu_sel;
    assign hs_fall = hs_r & ~hsync;
    assign vs_fall = vs_r & ~vsync;
    assign line10  = 10'(line_cnt);
    assign unused_bits = ^{ent.pad, ent.irq};

    vga_copper_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
        .cpu_clk (cpu_clk),
        .wr_en   (cop_wr && cpu_addr == REG_DATA),
        .wr_idx  (ptr[PW+1:2]),
        .wr_lane (ptr[1:0]),
        .wr_byte (cpu_dbw),
        .rd_idx  (idx[PW-1:0]),
        .rd_data (ent)
    );

    // CTRL enable and program pointer; the pointer skips unused lane 3.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            en  <= 1'b0;
            ptr <= '0;
        end else if (cop_wr) begin
            case (cpu_addr)
                REG_CTRL: en  <= cpu_dbw[0];
                REG_PTR:  ptr <= {cpu_dbw[PW-1:0], 2'b00};
                REG_DATA: ptr <= ptr + ((ptr[1:0] == 2'd2) ? PTR_TWO : PTR_ONE);
                default:  ;
            endcase
        end
    end

    // Previous-cycle copies of the active-low syncs for fall detection.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            hs_r <= 1'b1;
            vs_r <= 1'b1;
        end else begin
            hs_r <= hsync;
            vs_r <= vsync;
        end
    end

    // Raster line counter: cleared by vsync, counts hsync, saturates.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            line_cnt <= '0;
        end else if (vs_fall) begin
            line_cnt <= '0;
        end else if (hs_fall && line_cnt != '1) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

    // Replay sequencer: fetch entry, wait for its line, issue, advance.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            pend  <= 1'b0;
        end else begin
            if (vs_fall) begin
                idx <= '0;
            end
            if (!en) begin
                state <= S_IDLE;
                pend  <= 1'b0;
            end else if (vs_fall) begin
                state <= S_FETCH;
                pend  <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: state <= S_CMP;
                    S_CMP: begin
                        if (ent.line == END_LINE || idx[PW]) begin
                            state <= S_DONE;
                        end else if (line_cnt >= LINE_W'(ent.line)) begin
                            state <= S_ISSUE;
                            pend  <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (grant) begin
                            pend  <= 1'b0;
                            idx   <= idx + IDX_ONE;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    // Shared video port mux: CPU first, then the pending copper write.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        vga_we   = 1'b0;
        vga_addr = 3'd0;
        vga_dbw  = 8'h00;
        grant    = 1'b0;
        if (cpu_vga) begin
            vga_we   = 1'b1;
            vga_addr = cpu_addr;
            vga_dbw  = cpu_dbw;
        end else if (pend) begin
            vga_we   = 1'b1;
            vga_addr = ent.reg_sel;
            vga_dbw  = ent.data;
            grant    = 1'b1;
        end
    end

`ifdef VGA_COPPER_IRQ_EN
    // Raster interrupt: set by a flagged granted entry, cleared by writing
    // offset 4; a set in the same cycle as the clear wins.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (cop_wr && cpu_addr == REG_CTRL) begin
                irq_en <= cpu_dbw[1];
            end
            if (grant && ent.irq && irq_en) begin
                irq <= 1'b1;
            end else if (cop_wr && cpu_addr == REG_STAT2) begin
                irq <= 1'b0;
            end
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    // Copper register read selection.
    always_comb begin
        rd_mux = 8'h00;
        case (cpu_addr)
            REG_CTRL:  rd_mux = {6'b000000, irq_en, en};
            REG_STAT:  rd_mux = line10[7:0];
            REG_STAT2: rd_mux = {irq, state[1:0], 3'b000, line10[9:8]};
            default:   rd_mux = 8'h00;
        endcase
    end

    // Registered CPU read data.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            cpu_dbr <= 8'h00;
        end else begin
            cpu_dbr <= cpu_sel ? rd_mux : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_copper.sv
// tb_vga_copper: directed self-checking bench for vga_copper (DEPTH=16).
// Video-port writes are logged at negedge+1 with a cycle stamp; each test
// compares the log against hand-computed expectations.
module tb_vga_copper;

    logic       cpu_clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cpu_addr = 3'd0;
    logic [7:0] cpu_dbw = 8'h00;
    logic       cpu_we = 1'b0;
    logic       cpu_sel = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [7:0] cpu_dbr;
    logic [2:0] vga_addr;
    logic [7:0] vga_dbw;
    logic       vga_we;
    logic       irq;

    vga_copper dut (
        .cpu_clk (cpu_clk), .rst (rst),
        .cpu_addr(cpu_addr), .cpu_dbw(cpu_dbw), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .hsync   (hsync), .vsync(vsync),
        .cpu_dbr (cpu_dbr), .vga_addr(vga_addr), .vga_dbw(vga_dbw), .vga_we(vga_we),
        .irq     (irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  irq_rise = -1;
    int  fall_cyc [0:1023];
    wr_t log_q [$];

    always @(posedge cpu_clk) cyc <= cyc + 1;

    always begin
        wr_t w;
        @(negedge cpu_clk);
        #1;
        if (vga_we === 1'b1) begin
            w.addr = vga_addr;
            w.data = vga_dbw;
            w.cyc  = cyc;
            log_q.push_back(w);
        end
        if (irq === 1'b1 && irq_rise < 0) irq_rise = cyc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_wr(input logic sel, input logic [2:0] a, input logic [7:0] d);
        @(negedge cpu_clk);
        cpu_sel = sel; cpu_addr = a; cpu_dbw = d; cpu_we = 1'b1;
        @(negedge cpu_clk);
        cpu_we = 1'b0; cpu_sel = 1'b0; cpu_addr = 3'd0; cpu_dbw = 8'h00;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge cpu_clk);
        cpu_sel = 1'b1; cpu_addr = a; cpu_we = 1'b0;
        @(negedge cpu_clk);
        d = cpu_dbr;
        cpu_sel = 1'b0; cpu_addr = 3'd0;
    endtask

    task automatic write_entry(input int i, input logic [9:0] ln, input logic [2:0] r,
                               input logic f, input logic [7:0] d);
        cpu_wr(1'b1, 3'd1, 8'(i));
        cpu_wr(1'b1, 3'd2, ln[7:0]);
        cpu_wr(1'b1, 3'd2, {f, r, 2'b00, ln[9:8]});
        cpu_wr(1'b1, 3'd2, d);
    endtask

    // One vsync fall then nlines lines of 8 cycles; optional single-cycle CPU
    // write on cycle 2 of line hook_line (hsync falls on cycle 0).
    task automatic run_frame(input int nlines, input int hook_line, input logic hsel,
                             input logic [2:0] ha, input logic [7:0] hd);
        @(negedge cpu_clk); vsync = 1'b0;
        @(negedge cpu_clk); vsync = 1'b1;
        for (int l = 1; l <= nlines; l++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge cpu_clk);
                hsync = (c == 0) ? 1'b0 : 1'b1;
                if (c == 0 && l <= 1023) fall_cyc[l] = cyc;
                if (l == hook_line && c == 2) begin
                    cpu_sel = hsel; cpu_addr = ha; cpu_dbw = hd; cpu_we = 1'b1;
                end
                if (l == hook_line && c == 3) begin
                    cpu_we = 1'b0; cpu_sel = 1'b0; cpu_addr = 3'd0; cpu_dbw = 8'h00;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        repeat (3) @(negedge cpu_clk);
        #2;
        checks++; if (vga_we !== 1'b0) begin failures++; $display("FAIL reset_vga_we got=%b want=0", vga_we); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        checks++; if (cpu_dbr !== 8'h00) begin failures++; $display("FAIL reset_cpu_dbr got=%h want=00", cpu_dbr); end
        @(negedge cpu_clk); rst = 1'b0;
        cpu_rd(3'd0, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h want=00", rd); end
        cpu_rd(3'd4, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_stat2 got=%h want=00", rd); end
    endtask

    task automatic test_single();
        logic [7:0] rd;
        int lat;
        cpu_wr(1'b1, 3'd0, 8'h00);
        write_entry(0, 10'd40, 3'd1, 1'b0, 8'h79);
        write_entry(1, 10'h3FF, 3'd0, 1'b0, 8'h00);
        cpu_wr(1'b1, 3'd0, 8'h01);
        for (int f = 0; f < 2; f++) begin
            log_q.delete();
            run_frame(45, -1, 1'b0, 3'd0, 8'h00);
            checks++; if (log_q.size() != 1) begin failures++; $display("FAIL single_count frame=%0d got=%0d want=1", f, log_q.size()); end
            if (log_q.size() >= 1) begin
                checks++; if (log_q[0].addr !== 3'd1 || log_q[0].data !== 8'h79) begin
                    failures++; $display("FAIL single_write frame=%0d got=%h/%h want=1/79", f, log_q[0].addr, log_q[0].data); end
                lat = log_q[0].cyc - fall_cyc[40];
                checks++; if (lat < 1 || lat > 3) begin failures++; $display("FAIL single_latency frame=%0d got=%0d want=1..3", f, lat); end
            end
        end
        cpu_rd(3'd3, rd);
        checks++; if (rd !== 8'd45) begin failures++; $display("FAIL stat_line got=%h want=2d", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        cpu_wr(1'b1, 3'd0, 8'h00);
        write_entry(0, 10'd50, 3'd2, 1'b0, 8'h10);
        write_entry(1, 10'd50, 3'd3, 1'b0, 8'h20);
        write_entry(2, 10'h3FF, 3'd0, 1'b0, 8'h00);
        cpu_wr(1'b1, 3'd0, 8'h01);
        log_q.delete();
        run_frame(55, -1, 1'b0, 3'd0, 8'h00);
        checks++; if (log_q.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", log_q.size()); end
        if (log_q.size() >= 2) begin
            checks++; if (log_q[0].addr !== 3'd2 || log_q[0].data !== 8'h10) begin
                failures++; $display("FAIL b2b_first got=%h/%h want=2/10", log_q[0].addr, log_q[0].data); end
            checks++; if (log_q[1].addr !== 3'd3 || log_q[1].data !== 8'h20) begin
                failures++; $display("FAIL b2b_second got=%h/%h want=3/20", log_q[1].addr, log_q[1].data); end
            checks++; if (log_q[1].cyc - log_q[0].cyc != 3) begin
                failures++; $display("FAIL b2b_spacing got=%0d want=3", log_q[1].cyc - log_q[0].cyc); end
            lat = log_q[0].cyc - fall_cyc[50];
            checks++; if (lat < 1 || lat > 3) begin failures++; $display("FAIL b2b_latency got=%0d want=1..3", lat); end
        end
    endtask

    task automatic test_cpu_priority();
        cpu_wr(1'b1, 3'd0, 8'h00);
        write_entry(0, 10'd10, 3'd4, 1'b0, 8'hAA);
        write_entry(1, 10'h3FF, 3'd0, 1'b0, 8'h00);
        cpu_wr(1'b1, 3'd0, 8'h01);
        log_q.delete();
        run_frame(15, 10, 1'b0, 3'd0, 8'h05);
        checks++; if (log_q.size() != 2) begin failures++; $display("FAIL prio_count got=%0d want=2", log_q.size()); end
        if (log_q.size() >= 2) begin
            checks++; if (log_q[0].addr !== 3'd0 || log_q[0].data !== 8'h05) begin
                failures++; $display("FAIL prio_cpu got=%h/%h want=0/05", log_q[0].addr, log_q[0].data); end
            checks++; if (log_q[1].addr !== 3'd4 || log_q[1].data !== 8'hAA) begin
                failures++; $display("FAIL prio_copper got=%h/%h want=4/aa", log_q[1].addr, log_q[1].data); end
            checks++; if (log_q[1].cyc - log_q[0].cyc != 1) begin
                failures++; $display("FAIL prio_next_cycle got=%0d want=1", log_q[1].cyc - log_q[0].cyc); end
        end
    endtask

    task automatic test_mid_frame_enable();
        logic [7:0] rd;
        cpu_wr(1'b1, 3'd0, 8'h00);
        write_entry(0, 10'd20, 3'd5, 1'b0, 8'h33);
        write_entry(1, 10'h3FF, 3'd0, 1'b0, 8'h00);
        log_q.delete();
        run_frame(110, 100, 1'b1, 3'd0, 8'h01);
        checks++; if (log_q.size() != 0) begin failures++; $display("FAIL midframe_quiet got=%0d want=0", log_q.size()); end
        cpu_rd(3'd0, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL midframe_ctrl got=%h want=01", rd); end
        log_q.delete();
        run_frame(25, -1, 1'b0, 3'd0, 8'h00);
        checks++; if (log_q.size() != 1) begin failures++; $display("FAIL midframe_next_count got=%0d want=1", log_q.size()); end
        if (log_q.size() >= 1) begin
            checks++; if (log_q[0].addr !== 3'd5 || log_q[0].data !== 8'h33 || log_q[0].cyc - fall_cyc[20] > 3) begin
                failures++; $display("FAIL midframe_next_write got=%h/%h lat=%0d want=5/33 lat<=3",
                                     log_q[0].addr, log_q[0].data, log_q[0].cyc - fall_cyc[20]); end
        end
    endtask

    task automatic test_irq();
        logic [7:0] rd;
        cpu_wr(1'b1, 3'd0, 8'h00);
        write_entry(0, 10'd60, 3'd6, 1'b1, 8'h40);
        write_entry(1, 10'h3FF, 3'd0, 1'b0, 8'h00);
        cpu_wr(1'b1, 3'd0, 8'h03);
        log_q.delete();
        irq_rise = -1;
        run_frame(62, -1, 1'b0, 3'd0, 8'h00);
        checks++; if (log_q.size() != 1) begin failures++; $display("FAIL irq_write_count got=%0d want=1", log_q.size()); end
`ifdef VGA_COPPER_IRQ_EN
        if (log_q.size() >= 1) begin
            checks++; if (irq_rise != log_q[0].cyc + 1) begin
                failures++; $display("FAIL irq_rise got=%0d want=%0d", irq_rise, log_q[0].cyc + 1); end
        end
        cpu_rd(3'd0, rd);
        checks++; if (rd !== 8'h03) begin failures++; $display("FAIL irq_ctrl got=%h want=03", rd); end
        cpu_rd(3'd4, rd);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL irq_stat2 got=%h want=80", rd); end
        cpu_wr(1'b1, 3'd4, 8'h00);
        #2;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack got=%b want=0", irq); end
`else
        checks++; if (irq_rise != -1 || irq !== 1'b0) begin
            failures++; $display("FAIL irq_tied got_rise=%0d irq=%b want=-1/0", irq_rise, irq); end
        cpu_rd(3'd0, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL irq_ctrl got=%h want=01", rd); end
`endif
    endtask

    task automatic test_saturate();
        logic [7:0] rd;
        cpu_wr(1'b1, 3'd0, 8'h00);
        @(negedge cpu_clk); vsync = 1'b0;
        @(negedge cpu_clk); vsync = 1'b1;
        repeat (1030) begin
            @(negedge cpu_clk); hsync = 1'b0;
            @(negedge cpu_clk); hsync = 1'b1;
        end
        cpu_rd(3'd3, rd);
        checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL sat_stat got=%h want=ff", rd); end
        cpu_rd(3'd4, rd);
        checks++; if (rd !== 8'h03) begin failures++; $display("FAIL sat_stat2 got=%h want=03", rd); end
        @(negedge cpu_clk); vsync = 1'b0;
        @(negedge cpu_clk); vsync = 1'b1;
        cpu_rd(3'd3, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL vsync_clear got=%h want=00", rd); end
    endtask

    task automatic test_full_list_reset();
        logic [7:0] rd;
        cpu_wr(1'b1, 3'd0, 8'h00);
        cpu_wr(1'b1, 3'd1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cpu_wr(1'b1, 3'd2, 8'd5);
            cpu_wr(1'b1, 3'd2, {1'b0, 3'(i), 4'b0000});
            cpu_wr(1'b1, 3'd2, 8'h80 + 8'(i));
        end
        cpu_wr(1'b1, 3'd0, 8'h01);
        log_q.delete();
        run_frame(30, -1, 1'b0, 3'd0, 8'h00);
        checks++; if (log_q.size() != 16) begin failures++; $display("FAIL full_count got=%0d want=16", log_q.size()); end
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            checks++; if (log_q[i].addr !== 3'(i) || log_q[i].data !== 8'h80 + 8'(i)) begin
                failures++; $display("FAIL full_entry%0d got=%h/%h want=%h/%h", i, log_q[i].addr, log_q[i].data,
                                     3'(i), 8'h80 + 8'(i)); end
        end
        run_frame(4, -1, 1'b0, 3'd0, 8'h00);
        @(negedge cpu_clk); hsync = 1'b0;
        @(negedge cpu_clk); hsync = 1'b1;
        @(negedge cpu_clk);
        #2;
        checks++; if (vga_we !== 1'b1 || vga_dbw !== 8'h80) begin
            failures++; $display("FAIL issue_pending got=%b/%h want=1/80", vga_we, vga_dbw); end
        rst = 1'b1;
        #1;
        checks++; if (vga_we !== 1'b0) begin failures++; $display("FAIL rst_async_we got=%b want=0", vga_we); end
        @(negedge cpu_clk); rst = 1'b0;
        cpu_rd(3'd4, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_stat2 got=%h want=00", rd); end
        cpu_rd(3'd0, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rst_ctrl got=%h want=00", rd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cpu_priority();
        test_mid_frame_enable();
        test_irq();
        test_saturate();
        test_full_list_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
